// File: rtl/accel_mmio_ctrl.sv
// MMIO front end for a compute accelerator: a CPU-visible buffer RAM shared with
// the engine, plus CTRL/STATUS/LEN/TMO registers and a job FSM with a watchdog.
module accel_mmio_ctrl #(
  parameter logic [3:0] REGION    = 4'h4,
  parameter int         BUF_DEPTH = 256,
  parameter int         TIMEOUT_W = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [31:0]                  cpu_addr_in,
  input  logic [31:0]                  cpu_data_in,
  input  logic [3:0]                   cpu_write_enable_in,
  output logic [31:0]                  cpu_data_out,
  output logic                         irq_out,
  output logic                         eng_start_out,
  output logic                         eng_abort_out,
  output logic [1:0]                   eng_mode_out,
  output logic [$clog2(BUF_DEPTH):0]   eng_len_out,
  input  logic                         eng_done_in,
  input  logic [$clog2(BUF_DEPTH)-1:0] eng_rd_addr_in,
  input  logic [$clog2(BUF_DEPTH)-1:0] eng_wr_addr_in,
  input  logic [31:0]                  eng_wr_data_in,
  input  logic [3:0]                   eng_we_in,
  output logic [31:0]                  eng_rd_data_out
);

  localparam int AW = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_ABORT  = 2'd3
  } state_t;

  state_t                 state_r, next_state_s;
  logic [31:0]            mem_r [BUF_DEPTH];
  logic [31:0]            rd_data_r;
  logic [3:0]             ram_we_s;
  logic [AW-1:0]          ram_waddr_s, ram_raddr_s;
  logic [31:0]            ram_wdata_s;
  logic [1:0]             mode_r;
  logic                   irq_en_r;
  logic [31:0]            len_r;
  logic [TIMEOUT_W-1:0]   tmo_r, wd_r;
  logic                   done_r, err_len_r, err_tmo_r, err_bw_r;
  logic [31:0]            cpu_rdata_r, reg_rdata_s;
  logic                   ram_sel_r;
  logic                   start_s, abort_s;

  logic          hit_s, buf_sel_s, reg_blk_s, wr_any_s, rd_s, idle_s;
  logic          ctrl_wr_s, status_wr_s, len_wr_s, tmo_wr_s;
  logic          len_ok_s, job_go_s, go_bad_s, wd_expire_s, busy_wr_s;
  logic [AW-1:0] cpu_idx_s;
  logic          unused_s;

  assign hit_s       = (cpu_addr_in[19:16] == REGION);
  assign buf_sel_s   = hit_s & ~cpu_addr_in[15];
  assign reg_blk_s   = hit_s & cpu_addr_in[15] & (cpu_addr_in[14:4] == 11'd0);
  assign wr_any_s    = |cpu_write_enable_in;
  assign rd_s        = ~wr_any_s;
  assign idle_s      = (state_r == ST_IDLE);
  assign cpu_idx_s   = cpu_addr_in[AW+1:2];
  assign ctrl_wr_s   = reg_blk_s & wr_any_s & (cpu_addr_in[3:2] == 2'd0);
  assign status_wr_s = reg_blk_s & wr_any_s & (cpu_addr_in[3:2] == 2'd1);
  assign len_wr_s    = reg_blk_s & wr_any_s & (cpu_addr_in[3:2] == 2'd2);
  assign tmo_wr_s    = reg_blk_s & wr_any_s & (cpu_addr_in[3:2] == 2'd3);
  assign len_ok_s    = (len_r != 32'd0) && (len_r <= 32'(BUF_DEPTH));
  assign job_go_s    = idle_s & ctrl_wr_s & cpu_data_in[2] & len_ok_s;
  assign go_bad_s    = idle_s & ctrl_wr_s & cpu_data_in[2] & ~len_ok_s;
  assign wd_expire_s = (tmo_r != {TIMEOUT_W{1'b0}}) && (wd_r == tmo_r);
  assign busy_wr_s   = ~idle_s & ((buf_sel_s & wr_any_s) | ctrl_wr_s);
  assign unused_s    = ^{cpu_addr_in[31:20], cpu_addr_in[1:0]};

  // A RAM read is still in flight the cycle after a CPU buffer read.
  assign cpu_data_out    = ram_sel_r ? rd_data_r : cpu_rdata_r;
  assign eng_rd_data_out = rd_data_r;

  // RAM port ownership: CPU while idle, engine for the whole job.
  always_comb begin
    ram_we_s    = 4'b0000;
    ram_waddr_s = cpu_idx_s;
    ram_wdata_s = cpu_data_in;
    ram_raddr_s = cpu_idx_s;
    if (idle_s) begin
      ram_we_s = (buf_sel_s & wr_any_s) ? cpu_write_enable_in : 4'b0000;
    end else begin
      ram_we_s    = eng_we_in;
      ram_waddr_s = eng_wr_addr_in;
      ram_wdata_s = eng_wr_data_in;
      ram_raddr_s = eng_rd_addr_in;
    end
  end

  // Simple dual-port buffer RAM with byte-enabled writes and registered read.
  always_ff @(posedge clk_in) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we_s[b]) mem_r[ram_waddr_s][8*b +: 8] <= ram_wdata_s[8*b +: 8];
    end
    rd_data_r <= mem_r[ram_raddr_s];
  end

  // Register read mux; anything outside the register block reads 0.
  always_comb begin
    reg_rdata_s = 32'd0;
    if (reg_blk_s) begin
      case (cpu_addr_in[3:2])
        2'd0:    reg_rdata_s = {28'd0, irq_en_r, 1'b0, mode_r};
        2'd1:    reg_rdata_s = {27'd0, err_bw_r, err_tmo_r, err_len_r, done_r, ~idle_s};
        2'd2:    reg_rdata_s = len_r;
        2'd3:    reg_rdata_s = 32'(tmo_r);
        default: reg_rdata_s = 32'd0;
      endcase
    end else begin
      reg_rdata_s = 32'd0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // FSM next-state logic; a done pulse beats a same-cycle watchdog expiry.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:   next_state_s = job_go_s ? ST_LAUNCH : ST_IDLE;
      ST_LAUNCH: next_state_s = ST_RUN;
      ST_RUN: begin
        if (eng_done_in)      next_state_s = ST_IDLE;
        else if (wd_expire_s) next_state_s = ST_ABORT;
        else                  next_state_s = ST_RUN;
      end
      ST_ABORT:  next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the state being entered so the pulses register cleanly.
  always_comb begin
    start_s = 1'b0;
    abort_s = 1'b0;
    case (next_state_s)
      ST_LAUNCH: start_s = 1'b1;
      ST_ABORT:  abort_s = 1'b1;
      default: begin
        start_s = 1'b0;
        abort_s = 1'b0;
      end
    endcase
  end

  // Control/status registers, watchdog, engine outputs and CPU read data.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mode_r        <= 2'd0;
      irq_en_r      <= 1'b0;
      len_r         <= 32'd0;
      tmo_r         <= {TIMEOUT_W{1'b0}};
      wd_r          <= {TIMEOUT_W{1'b0}};
      done_r        <= 1'b0;
      err_len_r     <= 1'b0;
      err_tmo_r     <= 1'b0;
      err_bw_r      <= 1'b0;
      irq_out       <= 1'b0;
      eng_start_out <= 1'b0;
      eng_abort_out <= 1'b0;
      eng_mode_out  <= 2'd0;
      eng_len_out   <= {(AW+1){1'b0}};
      cpu_rdata_r   <= 32'd0;
      ram_sel_r     <= 1'b0;
    end else begin
      eng_start_out <= start_s;
      eng_abort_out <= abort_s;
      if (start_s) begin
        eng_mode_out <= cpu_data_in[1:0];
        eng_len_out  <= len_r[AW:0];
      end
      case (state_r)
        ST_LAUNCH: wd_r <= {TIMEOUT_W{1'b0}};
        ST_RUN:    wd_r <= wd_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        default:   wd_r <= wd_r;
      endcase
      if (ctrl_wr_s) begin
        irq_en_r <= cpu_data_in[3];
        if (idle_s) mode_r <= cpu_data_in[1:0];
      end
      if (len_wr_s) len_r <= cpu_data_in;
      if (tmo_wr_s) tmo_r <= cpu_data_in[TIMEOUT_W-1:0];
      // Hardware set has priority over the CPU write-1-to-clear.
      done_r    <= ((state_r == ST_RUN) & eng_done_in) |
                   (done_r & ~((status_wr_s & cpu_data_in[1]) | job_go_s));
      err_len_r <= go_bad_s | (err_len_r & ~((status_wr_s & cpu_data_in[2]) | job_go_s));
      err_tmo_r <= (state_r == ST_ABORT) |
                   (err_tmo_r & ~((status_wr_s & cpu_data_in[3]) | job_go_s));
      err_bw_r  <= busy_wr_s | (err_bw_r & ~(status_wr_s & cpu_data_in[4]));
      irq_out   <= irq_en_r & (done_r | err_len_r | err_tmo_r);
      if (rd_s) begin
        if (buf_sel_s & idle_s) begin
          ram_sel_r <= 1'b1;
        end else begin
          ram_sel_r   <= 1'b0;
          cpu_rdata_r <= reg_rdata_s;
        end
      end else if (ram_sel_r) begin
        cpu_rdata_r <= rd_data_r;
        ram_sel_r   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/accel_mmio_ctrl.md
ACCEL_MMIO_CTRL -- requirements
Module: accel_mmio_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter REGION, default 4'h4, SHALL be the MMIO region ID, matched against cpu_addr_in[19:16].
REQ-003 Parameter BUF_DEPTH, default 256, SHALL set the number of 32-bit buffer words; it SHALL be a power of 2, from 16 to 8192.
REQ-004 Parameter TIMEOUT_W, default 16, SHALL set the width of the job watchdog counter.
REQ-005 Ports SHALL be:
- clk_in  in  1  clock
- rst_in  in  1  sync reset
- cpu_addr_in  in  32  byte address
- cpu_data_in  in  32  write data
- cpu_write_enable_in  in  4  byte enables
- cpu_data_out  out  32  read data
- irq_out  out  1  level interrupt
- eng_start_out  out  1  job-start pulse
- eng_abort_out  out  1  job-abort pulse
- eng_mode_out  out  2  job mode
- eng_len_out  out  $clog2(BUF_DEPTH)+1  job length in words
- eng_done_in  in  1  job-complete pulse
- eng_rd_addr_in  in  $clog2(BUF_DEPTH)  engine read address
- eng_wr_addr_in  in  $clog2(BUF_DEPTH)  engine write address
- eng_wr_data_in  in  32  engine write data
- eng_we_in  in  4  engine byte enables
- eng_rd_data_out  out  32  engine read data, 1-cycle latency

Function
REQ-006 A region hit SHALL be cpu_addr_in[19:16]==REGION; with no hit, writes SHALL be ignored and cpu_data_out SHALL read 0 one cycle later.
REQ-007 Offsets 0x0000..0x7FFC SHALL map to the buffer, using word index cpu_addr_in[$clog2(BUF_DEPTH)+1:2]; index bits above that are ignored.
REQ-008 The register offsets SHALL be:
- CTRL at 0x8000: [1:0] mode, [2] go, [3] irq_en.
- STATUS at 0x8004: [0] busy, [1] done, [2] err_len, [3] err_timeout, [4] err_busy_wr.
- LEN at 0x8008: job length in words.
- TMO at 0x800C: watchdog limit.
REQ-009 Offsets 0x8010..0xFFFC SHALL read 0 and ignore writes.
REQ-010 Every CPU read SHALL have exactly 1 cycle latency, for both buffer and register reads; cpu_data_out SHALL hold its value until the next region read.
REQ-011 Register writes SHALL occur when any cpu_write_enable_in bit is set and SHALL write the full word; buffer writes SHALL honour per-byte enables.
REQ-012 The buffer SHALL be a simple dual-port synchronous RAM (1 read port, 1 write port) with registered read data.
REQ-013 In IDLE, the CPU SHALL own both RAM ports; in every other state, the engine SHALL own both.
REQ-014 CPU buffer writes outside IDLE SHALL be dropped and SHALL set err_busy_wr.
REQ-015 CPU buffer reads outside IDLE SHALL return 0.
REQ-016 The FSM SHALL have the states IDLE, LAUNCH, RUN and ABORT.
REQ-017 In IDLE, a CTRL write with go=1 and 1<=LEN<=BUF_DEPTH SHALL clear done, err_len and err_timeout, and move the FSM to LAUNCH.
REQ-018 In IDLE, a go=1 write with LEN=0 or LEN>BUF_DEPTH SHALL set err_len and leave the FSM in IDLE.
REQ-019 LAUNCH SHALL assert eng_start_out for exactly 1 cycle, latch mode and LEN onto eng_mode_out and eng_len_out, load the watchdog with 0, and go to RUN.
REQ-020 eng_mode_out and eng_len_out SHALL stay stable from LAUNCH until the FSM returns to IDLE.
REQ-021 In RUN, the watchdog SHALL increment each cycle.
REQ-022 eng_done_in in RUN SHALL set done and return the FSM to IDLE on the next cycle.
REQ-023 When the watchdog equals TMO and TMO!=0, with no eng_done_in that cycle, the FSM SHALL go to ABORT.
REQ-024 TMO=0 SHALL disable the watchdog.
REQ-025 ABORT SHALL assert eng_abort_out for 1 cycle, set err_timeout, and return to IDLE.
REQ-026 If eng_done_in and watchdog expiry occur in the same cycle, done SHALL win.
REQ-027 eng_done_in outside RUN SHALL be ignored.
REQ-028 CTRL writes outside IDLE SHALL update only irq_en, SHALL not start a job, and SHALL set err_busy_wr.
REQ-029 STATUS bits [4:1] SHALL be write-1-to-clear.
REQ-030 If hardware sets a STATUS bit in the same cycle the CPU clears it, the set SHALL win.
REQ-031 busy SHALL read 1 whenever the FSM is not in IDLE.
REQ-032 CTRL.go SHALL read back 0.
REQ-033 irq_out SHALL equal irq_en & (done | err_len | err_timeout), registered.

Reset
REQ-034 Reset SHALL force the FSM to IDLE.
REQ-035 Reset SHALL clear CTRL, STATUS, LEN, TMO and the watchdog to 0.
REQ-036 Reset SHALL set cpu_data_out, irq_out, eng_start_out, eng_abort_out, eng_mode_out and eng_len_out to 0.
REQ-037 Buffer contents SHALL be undefined after reset.
REQ-038 Reset mid-job SHALL not pulse eng_abort_out; the engine shares rst_in.

Verification
REQ-039 Loopback: write 0xA5A5_0001 to buffer word 3, then read it back -> 0xA5A5_0001 appears 1 cycle after the read address.
REQ-040 Byte-enable write: word 3 holds 0xA5A5_0001; write 0x1122_3344 with be=4'b0101 -> word 3 reads 0xA522_0044.
REQ-041 Normal job: LEN=4, TMO=0, CTRL=0b1101 (irq_en, go, mode 1), done pulse 10 cycles after start -> eng_start_out pulses once, eng_mode_out=1, eng_len_out=4, busy=1 during the job; then STATUS=0x02 and irq_out=1.
REQ-042 Writing 0x02 to STATUS after the normal job -> irq_out drops 1 cycle later.
REQ-043 Timeout: TMO=5, go with no done pulse -> eng_abort_out pulses, STATUS=0x08, FSM back in IDLE.
REQ-044 Errors:
- go with LEN=0 -> STATUS=0x04, and no start pulse.
- CPU buffer write during RUN -> RAM word unchanged, STATUS[4]=1.
- Reset during RUN -> all outputs 0, STATUS=0.
